// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP32 adder.
// One operation in flight at a time. The sum is returned with the requester ID
// over a valid/ready response channel.
module fp_add_arbiter #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        fa_start,
    output logic [31:0] fa_a,
    output logic [31:0] fa_b,
    output logic        fa_eop,
    input  logic [31:0] fa_sum,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_id_q, last_id_d;
    logic [31:0] fa_a_q, fa_a_d, fa_b_q, fa_b_d;
    logic        fa_eop_q, fa_eop_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;
    logic        grant0, grant1;
    logic [31:0] sel_a, sel_b;
    logic        sel_sub, sel_bsign;

    // Grant only from IDLE; on a tie the requester that did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_id_q;
                grant1 = ~last_id_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign sel_a     = grant1 ? req1_a : req0_a;
    assign sel_b     = grant1 ? req1_b : req0_b;
    assign sel_sub   = grant1 ? req1_sub : req0_sub;
    assign sel_bsign = sel_b[31] ^ sel_sub;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_id_d  = last_id_q;
        fa_a_d     = fa_a_q;
        fa_b_d     = fa_b_q;
        fa_eop_d   = fa_eop_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    state_d   = StIssue;
                    last_id_d = grant1;
                    rsp_id_d  = grant1;
                    fa_a_d    = sel_a;
                    fa_b_d    = {sel_bsign, sel_b[30:0]};
                    fa_eop_d  = sel_a[31] ^ sel_bsign;
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = 4'(LAT);
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_data_d = fa_sum;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            last_id_q  <= 1'b1;
            fa_a_q     <= 32'd0;
            fa_b_q     <= 32'd0;
            fa_eop_q   <= 1'b0;
            rsp_data_q <= 32'd0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_id_q  <= last_id_d;
            fa_a_q     <= fa_a_d;
            fa_b_q     <= fa_b_d;
            fa_eop_q   <= fa_eop_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign fa_start   = (state_q == StIssue);
    assign fa_a       = fa_a_q;
    assign fa_b       = fa_b_q;
    assign fa_eop     = fa_eop_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a LAT=3 instance for the main scenarios and a
// LAT=1 instance for the short-latency timing.
module tb_fp_add_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'h3F80_0000, req0_b = 32'h4000_0000;
    logic [31:0] req1_a = 32'h4040_0000, req1_b = 32'h3F80_0000;
    logic        req0_sub = 1'b0, req1_sub = 1'b1;
    logic        fa_start, fa_eop, rsp_valid, rsp_id, busy;
    logic [31:0] fa_a, fa_b, fa_sum, rsp_data;
    logic        rsp_ready = 1'b1;

    logic        u1_req0_valid = 1'b0;
    logic        u1_req0_ready, u1_req1_ready, u1_fa_start, u1_fa_eop;
    logic        u1_rsp_valid, u1_rsp_id, u1_busy;
    logic [31:0] u1_fa_a, u1_fa_b, u1_fa_sum, u1_rsp_data;

    logic [15:0] pipe3 = 16'd0, pipe1 = 16'd0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub),
        .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b), .fa_eop(fa_eop), .fa_sum(fa_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy)
    );

    fp_add_arbiter #(.LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(u1_req0_valid), .req0_ready(u1_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(1'b0), .req1_ready(u1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub),
        .fa_start(u1_fa_start), .fa_a(u1_fa_a), .fa_b(u1_fa_b), .fa_eop(u1_fa_eop),
        .fa_sum(u1_fa_sum),
        .rsp_valid(u1_rsp_valid), .rsp_ready(1'b1), .rsp_data(u1_rsp_data),
        .rsp_id(u1_rsp_id), .busy(u1_busy)
    );

    // Adder stand-in: hand-computed sums for the vectors used here; garbage off-cycle.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
        return 32'h7FC0_0000;
    endfunction

    always @(posedge clk) begin
        pipe3 <= {pipe3[14:0], fa_start};
        pipe1 <= {pipe1[14:0], u1_fa_start};
    end
    assign fa_sum    = pipe3[2] ? model_add(fa_a, fa_b) : 32'hDEAD_BEEF;
    assign u1_fa_sum = pipe1[0] ? model_add(u1_fa_a, u1_fa_b) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 30 && !rsp_valid; k++) @(negedge clk);
        check(tag, rsp_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 30 && busy; k++) @(negedge clk);
        check(tag, busy, 1'b0);
    endtask

    int gid[8];
    int gcyc[8];
    int ng, both, first_rsp;

    initial begin
        // Power-on reset
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_start", fa_start, 0);
        check("rst_fa_a", fa_a, 0);
        check("rst_fa_b", fa_b, 0);
        check("rst_eop", fa_eop, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single add: 1.0 + 2.0 from requester 0
        @(posedge clk); #1 req0_valid = 1'b1;
        @(negedge clk);
        check("add_rdy0", req0_ready, 1);
        check("add_rdy1", req1_ready, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("add_start", fa_start, 1);
        check("add_fa_a", fa_a, 32'h3F80_0000);
        check("add_fa_b", fa_b, 32'h4000_0000);
        check("add_eop", fa_eop, 0);
        check("add_busy", busy, 1);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("add_early_rspv", rsp_valid, 0);
            check("add_start_once", fa_start, 0);
        end
        @(negedge clk);
        check("add_rspv", rsp_valid, 1);
        check("add_data", rsp_data, 32'h4040_0000);
        check("add_id", rsp_id, 0);
        @(negedge clk);
        check("add_idle", busy, 0);

        // Subtract folding: 3.0 - 1.0 from requester 1
        @(posedge clk); #1 req1_valid = 1'b1;
        @(negedge clk);
        check("sub_rdy1", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("sub_fa_b", fa_b, 32'hBF80_0000);
        check("sub_eop", fa_eop, 1);
        wait_rsp("sub_rsp_to");
        check("sub_data", rsp_data, 32'h4000_0000);
        check("sub_id", rsp_id, 1);
        wait_idle("sub_idle_to");

        // Reset mid-WAIT after a requester-0 op (leaves last_id = 0 before reset)
        @(posedge clk); #1 req0_valid = 1'b1;
        @(posedge clk); #1 req0_valid = 1'b0;       // T+1
        @(posedge clk);                             // T+2, cnt = 3
        @(posedge clk); #1 rst_n = 1'b0;            // T+3, cnt = 2
        @(posedge clk); #1 begin
            rst_n = 1'b1;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
        end
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_rspv", rsp_valid, 0);
        check("mrst_start", fa_start, 0);

        // Round-robin tie after reset
        ng = 0; both = 0; first_rsp = -1;
        for (int i = 0; i < 28; i++) begin
            if (req0_ready && req1_ready) both++;
            if ((req0_ready || req1_ready) && ng < 8) begin
                gid[ng] = req1_ready ? 1 : 0;
                gcyc[ng] = i;
                ng++;
            end
            if (rsp_valid && first_rsp < 0) first_rsp = i;
            @(negedge clk);
        end
        check("rr_both", both, 0);
        check("rr_count", (ng >= 4), 1);
        check("rr_first_rsp", first_rsp, 5);
        for (int g = 0; g < 4; g++) check("rr_grant", gid[g], g % 2);
        for (int g = 0; g < 3; g++) check("rr_space", gcyc[g+1] - gcyc[g], 6);
        @(posedge clk); #1 begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        wait_idle("rr_idle_to");

        // Backpressure in RESP
        @(posedge clk); #1 req1_valid = 1'b1;
        @(negedge clk);
        check("bp_rdy1", req1_ready, 1);
        @(posedge clk); #1 begin
            req1_valid = 1'b0;
            rsp_ready = 1'b0;
        end
        wait_rsp("bp_rsp_to");
        req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rspv", rsp_valid, 1);
            check("bp_data", rsp_data, 32'h4000_0000);
            check("bp_id", rsp_id, 1);
            check("bp_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_busy", busy, 0);
        check("bp_resume_rdy0", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        wait_idle("bp_idle_to");

        // LAT=1 build timing
        @(posedge clk); #1 u1_req0_valid = 1'b1;
        @(negedge clk);
        check("l1_rdy0", u1_req0_ready, 1);
        @(posedge clk); #1 u1_req0_valid = 1'b0;
        @(negedge clk);
        check("l1_start", u1_fa_start, 1);
        @(negedge clk);
        check("l1_early_rspv", u1_rsp_valid, 0);
        check("l1_start_once", u1_fa_start, 0);
        @(negedge clk);
        check("l1_rspv", u1_rsp_valid, 1);
        check("l1_data", u1_rsp_data, 32'h4040_0000);
        check("l1_id", u1_rsp_id, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
